rf_access_ctrl: RTL and testbench
=================================

Name: rf_access_ctrl

Overview:
- Access controller sitting directly in front of reg_bank; owns all of its ports (reg_wen, addr_a, addr_b, data_i, data_o_a, data_o_b).
- reg_bank shares addr_a between write and read port A, so this block schedules operand reads from decode against writebacks from execute/load.
- Writebacks go into a small pending-write FIFO and drain into reg_bank in cycles with no read.
- Read operands are returned registered, one cycle after acceptance, with hazard handling against pending writes.

Parameters:
- DEPTH, 4, pending-write FIFO entries; power of 2, range 2..16.
- DW, 32, data width; must match reg_bank.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  reset, synchronous, active-low.
- wb_valid  input  1  writeback request valid.
- wb_ready  output  1  writeback accepted when wb_valid & wb_ready.
- wb_rd  input  5  destination register.
- wb_data  input  DW  writeback data.
- rd_valid  input  1  operand read request valid.
- rd_ready  output  1  read accepted when rd_valid & rd_ready.
- rs1  input  5  source A index.
- rs2  input  5  source B index.
- rsp_valid  output  1  one-cycle pulse; operands valid.
- rsp_a  output  DW  operand A.
- rsp_b  output  DW  operand B.
- reg_wen  output  1  to reg_bank; active-low write enable.
- addr_a  output  5  to reg_bank; write address or read address A.
- addr_b  output  5  to reg_bank; read address B.
- data_i  output  DW  to reg_bank write data.
- data_o_a  input  DW  from reg_bank.
- data_o_b  input  DW  from reg_bank.

Behaviour:
- Reset, when rstn is low at posedge: FIFO emptied (count=0, pointers=0), rsp_valid=0, rsp_a=0, rsp_b=0.
- During reset and after it: reg_wen=1, addr_a=0, addr_b=0, data_i=0, wb_ready=0, rd_ready=0 (ready outputs are gated by rstn).
- Reset mid-operation discards pending writes; reg_bank contents are unaffected.
- wb_ready = (count < DEPTH). An accepted write with wb_rd==0 is dropped and not pushed.
- Cycle slot arbitration is combinational, each cycle:
  - READ: rd_valid and no force-drain and no stall. rd_ready=1, addr_a=rs1, addr_b=rs2, reg_wen=1.
  - DRAIN: otherwise, if count>0. reg_wen=0, addr_a=head.rd, data_i=head.data, addr_b=0. Head is popped at posedge.
  - IDLE: otherwise. reg_wen=1, all addresses 0.
- Force-drain when count==DEPTH; rd_ready=0 that cycle.
- A push and a pop in the same cycle are legal; count is unchanged.
- Age order: a write accepted in cycle t is older than a read accepted in cycle t.
- The read result includes every accepted write, including a same-cycle wb, per the Optional Feature.
- Latency: a read accepted at posedge t gives rsp_valid=1 for cycle t+1, with rsp_a/rsp_b registered at t. There is no backpressure on rsp.
- rs==0 always yields 0.
- A write reaches reg_bank no earlier than one cycle after acceptance; FIFO drain order is strict FIFO.

Optional Feature:
- Macro RF_ACCESS_FWD_EN.
- Defined (forwarding): on read, each operand takes priority in this order:
  - same-cycle accepted wb (wb_rd matches, nonzero);
  - youngest matching FIFO entry;
  - reg_bank data_o.
  - Reads never stall on hazards.
- Undefined (stall): stall=1 when rs1 or rs2 (nonzero) matches any valid FIFO entry or the same-cycle accepted wb_rd.
  - rd_ready=0 and the DRAIN slot is used until no match remains.
  - The read then completes from reg_bank.

Test Plan:
- Reset, then wb r5=0xDEADBEEF with no reads → reg_wen low for exactly 1 cycle, addr_a=5, data_i=0xDEADBEEF. A later read rs1=5, rs2=0 gives rsp_a=0xDEADBEEF, rsp_b=0.
- wb r0=0x1234 → wb_ready=1, no push, reg_wen stays 1. Read rs1=0 gives 0.
- Continuous rd_valid with 5 wbs (DEPTH=4) → wb_ready drops at count=4; a force-drain cycle occurs with rd_ready=0; all 5 writes land in order; no write is lost.
- Same cycle: wb r7=0xA5A5A5A5 and read rs1=7.
  - FWD_EN: rsp_a=0xA5A5A5A5 next cycle, no stall.
  - No FWD: rd_ready=0 until r7 drains, then rsp_a=0xA5A5A5A5.
- FIFO holds r3=1 then r3=2; read rs2=3 → rsp_b=2 in both modes, either forwarded or after drain.
- 3 writes pending, rstn low for 1 cycle mid-drain → count=0, rsp_valid=0, reg_wen=1. Undrained registers read their old values.

Source files
------------

// File: rtl/rf_access_ctrl.sv
// Access controller in front of reg_bank: queues writebacks in a pending-write FIFO and
// schedules operand reads against FIFO drains. Define RF_ACCESS_FWD_EN to forward instead of stall.
module rf_access_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [4:0]    wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_a,
    output logic [DW-1:0] rsp_b,
    output logic          reg_wen,
    output logic [4:0]    addr_a,
    output logic [4:0]    addr_b,
    output logic [DW-1:0] data_i,
    input  logic [DW-1:0] data_o_a,
    input  logic [DW-1:0] data_o_b
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [DW-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;

    logic          full, push, pop, rd_go, stall;
    logic [DW-1:0] opnd_a, opnd_b;

    assign wb_ready = rstn && (count_q < DepthC);
    assign push     = wb_valid && wb_ready && (wb_rd != 5'd0);
    assign full     = (count_q == DepthC);

`ifdef RF_ACCESS_FWD_EN
    // Newest value wins: same-cycle writeback, then youngest queued entry, then the bank.
    function automatic logic [DW-1:0] fwd_operand(input logic [4:0] rs, input logic [DW-1:0] bank);
        logic [DW-1:0] val;
        logic [PW-1:0] idx;
        val = bank;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if ((CW'(i) < count_q) && (fifo_rd_q[idx] == rs)) val = fifo_data_q[idx];
        end
        if (push && (wb_rd == rs)) val = wb_data;
        if (rs == 5'd0) val = '0;
        return val;
    endfunction

    always_comb begin
        stall  = 1'b0;
        opnd_a = fwd_operand(rs1, data_o_a);
        opnd_b = fwd_operand(rs2, data_o_b);
    end
`else
    function automatic logic pending_hit(input logic [4:0] rs);
        logic          hit;
        logic [PW-1:0] idx;
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if ((CW'(i) < count_q) && (fifo_rd_q[idx] == rs)) hit = 1'b1;
        end
        if (push && (wb_rd == rs)) hit = 1'b1;
        return hit && (rs != 5'd0);
    endfunction

    always_comb begin
        stall  = pending_hit(rs1) || pending_hit(rs2);
        opnd_a = (rs1 == 5'd0) ? '0 : data_o_a;
        opnd_b = (rs2 == 5'd0) ? '0 : data_o_b;
    end
`endif

    always_comb begin
        rd_ready    = rstn && !full && !stall;
        rd_go       = rd_valid && rd_ready;
        pop         = rstn && !rd_go && (count_q != '0);
        reg_wen     = 1'b1;
        addr_a      = 5'd0;
        addr_b      = 5'd0;
        data_i      = '0;
        if (rd_go) begin
            addr_a = rs1;
            addr_b = rs2;
        end else if (pop) begin
            reg_wen = 1'b0;
            addr_a  = fifo_rd_q[rptr_q];
            data_i  = fifo_data_q[rptr_q];
        end
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        rsp_valid_d = rd_go;
        rsp_a_d     = rd_go ? opnd_a : rsp_a_q;
        rsp_b_d     = rd_go ? opnd_b : rsp_b_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= wb_rd;
            fifo_data_q[wptr_q] <= wb_data;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural reg_bank (sync write, async read).
module tb_rf_access_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rd_valid, rd_ready;
    logic [4:0]  rs1, rs2;
    logic        rsp_valid;
    logic [31:0] rsp_a, rsp_b;
    logic        reg_wen;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_i, data_o_a, data_o_b;

    logic [31:0] mem [32];
    logic        init_mem;
    logic [4:0]  wlog_a [$];
    logic [31:0] wlog_d [$];
    int          total = 0;
    int          bad   = 0;
    int          n;

    always #5 clk = ~clk;

    rf_access_ctrl #(.DEPTH(4), .DW(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rs1      (rs1),
        .rs2      (rs2),
        .rsp_valid(rsp_valid),
        .rsp_a    (rsp_a),
        .rsp_b    (rsp_b),
        .reg_wen  (reg_wen),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .data_i   (data_i),
        .data_o_a (data_o_a),
        .data_o_b (data_o_b)
    );

    // r0 holds junk so a zero operand must come from the controller, not the bank.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0100_0000 | 32'(i);
            mem[0] <= 32'hBAD0_0000;
        end else if (reg_wen === 1'b0) begin
            mem[addr_a] <= data_i;
            wlog_a.push_back(addr_a);
            wlog_d.push_back(data_i);
        end
    end

    assign data_o_a = mem[addr_a];
    assign data_o_b = mem[addr_b];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with requests asserted: nothing may be accepted or written.
        init_mem = 1'b1;
        rstn     = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hFFFF_FFFF;
        rd_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd4;
        #1;
        chk1("rst_wb_ready", wb_ready, 1'b0);
        chk1("rst_rd_ready", rd_ready, 1'b0);
        chk1("rst_reg_wen", reg_wen, 1'b1);
        chk5("rst_addr_a", addr_a, 5'd0);
        chk5("rst_addr_b", addr_b, 5'd0);
        chk32("rst_data_i", data_i, 32'h0);
        tick();
        init_mem = 1'b0;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_rsp_a", rsp_a, 32'h0);
        chk32("rst_rsp_b", rsp_b, 32'h0);
        tick();

        // Single writeback drains in exactly one cycle, then reads back.
        rstn = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; rd_valid = 1'b0;
        #1;
        chk1("t1_wb_ready", wb_ready, 1'b1);
        chk1("t1_idle_wen", reg_wen, 1'b1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk1("t1_drain_wen", reg_wen, 1'b0);
        chk5("t1_drain_addr", addr_a, 5'd5);
        chk32("t1_drain_data", data_i, 32'hDEAD_BEEF);
        chk5("t1_drain_addr_b", addr_b, 5'd0);
        tick();
        chk1("t1_wen_released", reg_wen, 1'b1);
        rd_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
        #1;
        chk1("t1_rd_ready", rd_ready, 1'b1);
        chk5("t1_read_addr_a", addr_a, 5'd5);
        tick();
        rd_valid = 1'b0;
        #1;
        chk1("t1_rsp_valid", rsp_valid, 1'b1);
        chk32("t1_rsp_a", rsp_a, 32'hDEAD_BEEF);
        chk32("t1_rsp_b", rsp_b, 32'h0);
        tick();
        chk1("t1_rsp_pulse", rsp_valid, 1'b0);

        // Writeback to r0 is accepted and dropped.
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
        #1;
        chk1("t2_wb_ready", wb_ready, 1'b1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk1("t2_no_write", reg_wen, 1'b1);
        rd_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
        tick();
        rd_valid = 1'b0;
        #1;
        chk1("t2_rsp_valid", rsp_valid, 1'b1);
        chk32("t2_rsp_a_zero", rsp_a, 32'h0);
        chk32("t2_rsp_b_zero", rsp_b, 32'h0);

        // Continuous reads with five writebacks: fill, force-drain, ordered drain.
        wlog_a.delete();
        wlog_d.delete();
        rd_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2; wb_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_rd = 5'(10 + i); wb_data = 32'hC0DE_0000 + 32'(10 + i);
            #1;
            chk1("t3_fill_wb_ready", wb_ready, 1'b1);
            chk1("t3_fill_rd_ready", rd_ready, 1'b1);
            tick();
        end
        wb_rd = 5'd14; wb_data = 32'hC0DE_000E;
        #1;
        chk1("t3_full_wb_ready", wb_ready, 1'b0);
        chk1("t3_full_rd_ready", rd_ready, 1'b0);
        chk1("t3_force_drain_wen", reg_wen, 1'b0);
        chk5("t3_force_drain_addr", addr_a, 5'd10);
        chk32("t3_rsp_a", rsp_a, 32'h0100_0001);
        chk32("t3_rsp_b", rsp_b, 32'h0100_0002);
        tick();
        chk1("t3_after_wb_ready", wb_ready, 1'b1);
        chk1("t3_after_rd_ready", rd_ready, 1'b1);
        chk1("t3_after_wen", reg_wen, 1'b1);
        chk1("t3_no_rsp_on_drain", rsp_valid, 1'b0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk1("t3_full2_rd_ready", rd_ready, 1'b0);
        chk1("t3_full2_wen", reg_wen, 1'b0);
        chk5("t3_full2_addr", addr_a, 5'd11);
        tick();
        rd_valid = 1'b0;
        n = 0;
        while (wlog_a.size() < 5 && n < 12) begin
            n++;
            tick();
        end
        chk32("t3_write_count", 32'(wlog_a.size()), 32'd5);
        for (int j = 0; j < 5; j++) begin
            if (j < wlog_a.size()) begin
                chk5("t3_order_addr", wlog_a[j], 5'(10 + j));
                chk32("t3_order_data", wlog_d[j], 32'hC0DE_0000 + 32'(10 + j));
            end
        end

        // Same-cycle writeback and read of r7.
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5_A5A5;
        rd_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd0;
`ifdef RF_ACCESS_FWD_EN
        #1;
        chk1("t4_fwd_rd_ready", rd_ready, 1'b1);
        tick();
        wb_valid = 1'b0; rd_valid = 1'b0;
        #1;
        chk1("t4_rsp_valid", rsp_valid, 1'b1);
        chk32("t4_rsp_a", rsp_a, 32'hA5A5_A5A5);
        chk1("t4_drain_wen", reg_wen, 1'b0);
        chk5("t4_drain_addr", addr_a, 5'd7);
        tick();
`else
        #1;
        chk1("t4_stall_rd_ready", rd_ready, 1'b0);
        chk1("t4_stall_idle_wen", reg_wen, 1'b1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk1("t4_stall2_rd_ready", rd_ready, 1'b0);
        chk1("t4_drain_wen", reg_wen, 1'b0);
        chk5("t4_drain_addr", addr_a, 5'd7);
        tick();
        chk1("t4_go_rd_ready", rd_ready, 1'b1);
        chk5("t4_go_addr_a", addr_a, 5'd7);
        tick();
        rd_valid = 1'b0;
        #1;
        chk1("t4_rsp_valid", rsp_valid, 1'b1);
        chk32("t4_rsp_a", rsp_a, 32'hA5A5_A5A5);
        tick();
`endif

        // Two queued writes to r3; read must see the younger one.
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1;
        rd_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
        #1;
        chk1("t5_fill_rd_ready", rd_ready, 1'b1);
        tick();
        wb_data = 32'h2;
        tick();
        wb_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd3;
`ifdef RF_ACCESS_FWD_EN
        #1;
        chk1("t5_fwd_rd_ready", rd_ready, 1'b1);
        tick();
        rd_valid = 1'b0;
        #1;
`else
        n = 0;
        #1;
        while (rd_ready !== 1'b1 && n < 10) begin
            n++;
            tick();
        end
        chk32("t5_stall_cycles", 32'(n), 32'd2);
        tick();
        rd_valid = 1'b0;
        #1;
`endif
        chk1("t5_rsp_valid", rsp_valid, 1'b1);
        chk32("t5_rsp_b", rsp_b, 32'h2);
        chk32("t5_rsp_a", rsp_a, 32'h0);
        for (int k = 0; k < 4; k++) tick();

        // Reset mid-drain discards the two undrained writes.
        wb_valid = 1'b1; rd_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
        for (int i = 0; i < 3; i++) begin
            wb_rd = 5'(20 + i); wb_data = 32'hAAAA_0020 + 32'(i);
            tick();
        end
        wb_valid = 1'b0; rd_valid = 1'b0;
        #1;
        chk1("t6_drain_wen", reg_wen, 1'b0);
        chk5("t6_drain_addr", addr_a, 5'd20);
        tick();
        rstn = 1'b0;
        #1;
        chk1("t6_rst_wen", reg_wen, 1'b1);
        chk1("t6_rst_wb_ready", wb_ready, 1'b0);
        chk1("t6_rst_rd_ready", rd_ready, 1'b0);
        chk5("t6_rst_addr_a", addr_a, 5'd0);
        chk32("t6_rst_data_i", data_i, 32'h0);
        tick();
        rstn = 1'b1;
        #1;
        chk1("t6_rsp_valid", rsp_valid, 1'b0);
        chk32("t6_rsp_a_cleared", rsp_a, 32'h0);
        chk32("t6_rsp_b_cleared", rsp_b, 32'h0);
        chk1("t6_idle_wen", reg_wen, 1'b1);
        rd_valid = 1'b1; rs1 = 5'd21; rs2 = 5'd22;
        tick();
        rs1 = 5'd20; rs2 = 5'd5;
        #1;
        chk32("t6_old_r21", rsp_a, 32'h0100_0015);
        chk32("t6_old_r22", rsp_b, 32'h0100_0016);
        tick();
        rd_valid = 1'b0;
        #1;
        chk32("t6_new_r20", rsp_a, 32'hAAAA_0020);
        chk32("t6_r5_kept", rsp_b, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
